// File: rtl/config_pkg.sv
// Shared types and constants for the machine-timer CSR block.
package config_pkg;

  localparam int CsrAddrW      = 12;
  localparam int MTimerTopMaxW = 24;
  localparam int MTimerPreMaxW = 5;

  typedef logic [CsrAddrW-1:0] CsrAddrT;

  localparam CsrAddrT MTimerBaseAddr = 12'hB00;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2
  } csr_op_t;

  typedef struct packed {
    logic [MTimerTopMaxW-1:0] top;
    logic                     cascade;
    logic [MTimerPreMaxW-1:0] pre;
    logic                     oneshot;
    logic                     en;
  } MTimerCtrlT;

  typedef enum logic {
    MT_IDLE = 1'b0,
    MT_RUN  = 1'b1
  } mtimer_state_e;

  // Result of a CSR write/set/clear against the current register value.
  function automatic MTimerCtrlT csr_apply(input csr_op_t op, input MTimerCtrlT cur,
                                           input logic [31:0] wdata);
    case (op)
      CSR_WRITE: return MTimerCtrlT'(wdata);
      CSR_SET:   return MTimerCtrlT'(cur | wdata);
      CSR_CLEAR: return MTimerCtrlT'(cur & ~wdata);
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/mtimer_channel.sv
// One timer channel: IDLE/RUN FSM, prescaler, compare counter and pending flag.
// With MTIMER_CASCADE_EN the channel can tick from the previous channel's expiry.
module mtimer_channel
  import config_pkg::*;
#(
  parameter int TopWidth   = 24,
  parameter int PreWidth   = 4
`ifdef MTIMER_CASCADE_EN
  ,
  parameter bit HasCascade = 1'b0
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ctrl_wr,
  input  MTimerCtrlT          ctrl_wdata,
`ifdef MTIMER_CASCADE_EN
  input  logic                casc_tick,
  output logic                expire,
`endif
  input  logic                irq_clear,
  output MTimerCtrlT          ctrl,
  output logic [TopWidth-1:0] count,
  output logic                irq
);

  // Prescaler must reach 2^pre-1 for the largest encodable pre.
  localparam int PcW = (1 << PreWidth) - 1;

  mtimer_state_e       state_q, state_d;
  logic                oneshot_q, oneshot_d;
  logic [PreWidth-1:0] pre_q, pre_d;
  logic [TopWidth-1:0] top_q, top_d, cnt_q, cnt_d;
  logic [PcW-1:0]      pcnt_q, pcnt_d, pcnt_lim;
  logic                irq_q, irq_d;
  logic                run, self_pre, tick, expiry;
`ifdef MTIMER_CASCADE_EN
  logic                casc_q, casc_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MT_IDLE;
      oneshot_q <= 1'b0;
      pre_q     <= '0;
      top_q     <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      irq_q     <= 1'b0;
`ifdef MTIMER_CASCADE_EN
      casc_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      oneshot_q <= oneshot_d;
      pre_q     <= pre_d;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      irq_q     <= irq_d;
`ifdef MTIMER_CASCADE_EN
      casc_q    <= casc_d;
`endif
    end
  end

  always_comb begin
    run      = (state_q == MT_RUN);
    self_pre = 1'b1;
    pcnt_lim = ~({PcW{1'b1}} << pre_q);
    tick     = run && (pcnt_q == pcnt_lim);
`ifdef MTIMER_CASCADE_EN
    if (casc_q) begin
      self_pre = 1'b0;
      tick     = run && casc_tick;
    end
`endif
    expiry = tick && (cnt_q == top_q);
  end

  // A CSR write wins over the oneshot auto-clear landing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (ctrl_wr) state_d = ctrl_wdata.en ? MT_RUN : MT_IDLE;
    else if (expiry && oneshot_q) state_d = MT_IDLE;
  end

  always_comb begin
    oneshot_d = oneshot_q;
    pre_d     = pre_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
`ifdef MTIMER_CASCADE_EN
    casc_d    = casc_q;
`endif
    if (ctrl_wr) begin
      oneshot_d = ctrl_wdata.oneshot;
      pre_d     = ctrl_wdata.pre[PreWidth-1:0];
      top_d     = ctrl_wdata.top[TopWidth-1:0];
      cnt_d     = '0;
      pcnt_d    = '0;
`ifdef MTIMER_CASCADE_EN
      casc_d    = HasCascade && ctrl_wdata.cascade;
`endif
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = expiry ? '0 : cnt_q + TopWidth'(1);
    end else if (run && self_pre) begin
      pcnt_d = pcnt_q + PcW'(1);
    end
    irq_d = expiry | (irq_q & ~irq_clear);
  end

  always_comb begin
    ctrl                     = '0;
    ctrl.en                  = (state_q == MT_RUN);
    ctrl.oneshot             = oneshot_q;
    ctrl.pre[PreWidth-1:0]   = pre_q;
    ctrl.top[TopWidth-1:0]   = top_q;
`ifdef MTIMER_CASCADE_EN
    ctrl.cascade             = casc_q;
    expire                   = expiry;
`endif
    count                    = cnt_q;
    irq                      = irq_q;
  end

endmodule

// File: rtl/mtimer.sv
// Multi-channel machine timer: CSR decode and read mux around NumCh channels.
// Define MTIMER_CASCADE_EN to let channel ch>0 count channel ch-1 expiries.
module mtimer
  import config_pkg::*;
#(
  parameter int      NumCh    = 4,
  parameter int      TopWidth = 24,
  parameter int      PreWidth = 4,
  parameter CsrAddrT BaseAddr = MTimerBaseAddr
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             csr_enable,
  input  CsrAddrT          csr_addr,
  input  csr_op_t          csr_op,
  input  logic [31:0]      csr_wdata,
  input  logic [NumCh-1:0] interrupt_clear,
  output logic [NumCh-1:0] interrupt_set,
  output logic [31:0]      csr_out
);

  MTimerCtrlT [NumCh-1:0]                ctrl;
  MTimerCtrlT [NumCh-1:0]                wr_data;
  logic       [NumCh-1:0][TopWidth-1:0]  cnt;
  logic       [NumCh-1:0]                ctrl_wr;
`ifdef MTIMER_CASCADE_EN
  logic       [NumCh-1:0]                expire, casc_in;
`endif

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    assign ctrl_wr[g] = csr_enable && (csr_addr == CsrAddrT'(BaseAddr + g));
    assign wr_data[g] = csr_apply(csr_op, ctrl[g], csr_wdata);
`ifdef MTIMER_CASCADE_EN
    if (g == 0) begin : g_head
      assign casc_in[g] = 1'b0;
    end else begin : g_link
      assign casc_in[g] = expire[g-1];
    end
`endif

    mtimer_channel #(
      .TopWidth  (TopWidth),
      .PreWidth  (PreWidth)
`ifdef MTIMER_CASCADE_EN
      ,
      .HasCascade(g > 0)
`endif
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_wr   (ctrl_wr[g]),
      .ctrl_wdata(wr_data[g]),
`ifdef MTIMER_CASCADE_EN
      .casc_tick (casc_in[g]),
      .expire    (expire[g]),
`endif
      .irq_clear (interrupt_clear[g]),
      .ctrl      (ctrl[g]),
      .count     (cnt[g]),
      .irq       (interrupt_set[g])
    );
  end

  // Reads see the registers before any same-cycle write lands.
  always_comb begin
    csr_out = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (csr_addr == CsrAddrT'(BaseAddr + i))         csr_out = ctrl[i];
      if (csr_addr == CsrAddrT'(BaseAddr + NumCh + i)) csr_out = 32'(cnt[i]);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Scoreboard bench for mtimer: expected interrupt levels are queued per cycle
// as stimulus is issued and checked at the falling edge of that cycle.
module tb_mtimer;
  import config_pkg::*;

  localparam int      NumCh = 4;
  localparam CsrAddrT Base  = MTimerBaseAddr;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             csr_enable = 1'b0;
  CsrAddrT          csr_addr = '0;
  csr_op_t          csr_op = CSR_WRITE;
  logic [31:0]      csr_wdata = '0;
  logic [NumCh-1:0] interrupt_clear = '0;
  logic [NumCh-1:0] interrupt_set;
  logic [31:0]      csr_out;

  always #5 clk = ~clk;

  mtimer #(.NumCh(NumCh), .TopWidth(24), .PreWidth(4), .BaseAddr(Base)) dut (
    .clk            (clk),
    .reset          (reset),
    .csr_enable     (csr_enable),
    .csr_addr       (csr_addr),
    .csr_op         (csr_op),
    .csr_wdata      (csr_wdata),
    .interrupt_clear(interrupt_clear),
    .interrupt_set  (interrupt_set),
    .csr_out        (csr_out)
  );

  int               cyc = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  int               exp_cyc_q[$];
  string            exp_tag_q[$];
  logic [NumCh-1:0] exp_irq_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void expect_irq(input int c, input string tag, input logic [NumCh-1:0] v);
    exp_cyc_q.push_back(c);
    exp_tag_q.push_back(tag);
    exp_irq_q.push_back(v);
  endfunction

  function automatic logic [31:0] ctrl_word(input logic en, input logic os, input logic [4:0] pre,
                                            input logic casc, input logic [23:0] top);
    return {top, casc, pre, os, en};
  endfunction

  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      int               c;
      string            t;
      logic [NumCh-1:0] v;
      c = exp_cyc_q.pop_front();
      t = exp_tag_q.pop_front();
      v = exp_irq_q.pop_front();
      if (c < cyc) chk({t, "_missed"}, cyc, c);
      else         chk(t, 32'(interrupt_set), 32'(v));
    end
  end

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic csr_wr(input CsrAddrT a, input csr_op_t op, input logic [31:0] d);
    @(posedge clk); #1;
    csr_enable = 1'b1; csr_addr = a; csr_op = op; csr_wdata = d;
    @(posedge clk); #1;
    csr_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input CsrAddrT a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_out, exp);
  endtask

  task automatic do_reset;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int cw;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;

    // reset state
    expect_irq(cyc, "irq_rst", '0);
    for (int i = 0; i < 2 * NumCh; i++) begin
      rd($sformatf("rst_reg%0d", i), CsrAddrT'(Base + i), 32'h0);
      @(posedge clk); #1;
    end

    // free-running, pre=0 top=3
    csr_wr(Base, CSR_WRITE, ctrl_word(1, 0, 0, 0, 3));
    cw = cyc;
    expect_irq(cw + 3, "t1_pre", 4'b0000);
    expect_irq(cw + 4, "t1_rise", 4'b0001);
    rd("t1_ctrl", Base, ctrl_word(1, 0, 0, 0, 3));
    tick_to(cw + 4);
    interrupt_clear = 4'b0001;
    expect_irq(cw + 5, "t1_clr", 4'b0000);
    expect_irq(cw + 7, "t1_wait", 4'b0000);
    expect_irq(cw + 8, "t1_rise2", 4'b0001);
    @(posedge clk); #1;
    interrupt_clear = '0;
    rd("t1_cnt", CsrAddrT'(Base + NumCh), 32'd1);
    tick_to(cw + 9);
    do_reset;

    // oneshot pre=2 top=1
    csr_wr(Base, CSR_WRITE, ctrl_word(1, 1, 2, 0, 1));
    cw = cyc;
    expect_irq(cw + 7, "t2_pre", 4'b0000);
    expect_irq(cw + 8, "t2_fire", 4'b0001);
    tick_to(cw + 8);
    rd("t2_ctrl", Base, ctrl_word(0, 1, 2, 0, 1));
    rd("t2_cnt", CsrAddrT'(Base + NumCh), 32'd0);
    interrupt_clear = 4'b0001;
    expect_irq(cw + 9, "t2_clr", 4'b0000);
    expect_irq(cw + 20, "t2_quiet", 4'b0000);
    expect_irq(cw + 30, "t2_quiet2", 4'b0000);
    @(posedge clk); #1;
    interrupt_clear = '0;
    tick_to(cw + 12);
    rd("t2_frozen", CsrAddrT'(Base + NumCh), 32'd0);
    tick_to(cw + 31);
    do_reset;

    // clear vs expiry on channel 1
    csr_wr(CsrAddrT'(Base + 1), CSR_WRITE, ctrl_word(1, 0, 0, 0, 1));
    cw = cyc;
    expect_irq(cw + 1, "t3_pre", 4'b0000);
    expect_irq(cw + 2, "t3_hold", 4'b0010);
    expect_irq(cw + 3, "t3_clr", 4'b0000);
    expect_irq(cw + 4, "t3_rearm", 4'b0010);
    tick_to(cw + 1);
    interrupt_clear = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    interrupt_clear = '0;
    tick_to(cw + 5);
    do_reset;

    // channel 2: set-op restart, CNT/unmapped writes ignored, pre-update read
    csr_wr(CsrAddrT'(Base + 2), CSR_WRITE, ctrl_word(1, 0, 0, 0, 10));
    cw = cyc;
    tick_to(cw + 5);
    rd("t4_cnt5", CsrAddrT'(Base + NumCh + 2), 32'd5);
    csr_wr(CsrAddrT'(Base + 2), CSR_SET, 32'h1);
    cw = cyc;
    rd("t4_restart", CsrAddrT'(Base + NumCh + 2), 32'd0);
    tick_to(cw + 1);
    rd("t4_cnt1", CsrAddrT'(Base + NumCh + 2), 32'd1);
    csr_wr(CsrAddrT'(Base + NumCh + 2), CSR_WRITE, 32'hFF);
    rd("t4_cntwr", CsrAddrT'(Base + NumCh + 2), 32'd3);
    csr_wr(CsrAddrT'(Base + 2 * NumCh), CSR_WRITE, 32'hFFFF_FFFF);
    rd("t4_unmapped", CsrAddrT'(Base + 2 * NumCh), 32'd0);
    rd("t4_ctrl2", CsrAddrT'(Base + 2), ctrl_word(1, 0, 0, 0, 10));
    rd("t4_ctrl0", Base, 32'd0);
    @(posedge clk); #1;
    csr_enable = 1'b1; csr_addr = CsrAddrT'(Base + 2); csr_op = CSR_CLEAR; csr_wdata = 32'h1;
    #1;
    chk("t4_preupd", csr_out, ctrl_word(1, 0, 0, 0, 10));
    @(posedge clk); #1;
    csr_enable = 1'b0;
    cw = cyc;
    rd("t4_stopped", CsrAddrT'(Base + 2), ctrl_word(0, 0, 0, 0, 10));
    tick_to(cw + 3);
    rd("t4_idlecnt", CsrAddrT'(Base + NumCh + 2), 32'd0);
    do_reset;

    // writable-field masking
    csr_wr(CsrAddrT'(Base + 3), CSR_WRITE, 32'hFFFF_FFFF);
`ifdef MTIMER_CASCADE_EN
    rd("t5_mask3", CsrAddrT'(Base + 3), 32'hFFFF_FFBF);
`else
    rd("t5_mask3", CsrAddrT'(Base + 3), 32'hFFFF_FF3F);
`endif
    csr_wr(Base, CSR_WRITE, 32'hFFFF_FFFF);
    rd("t5_mask0", Base, 32'hFFFF_FF3F);
    do_reset;

    // reset mid-period
    csr_wr(Base, CSR_WRITE, ctrl_word(1, 0, 0, 0, 3));
    cw = cyc;
    tick_to(cw + 2);
    rd("t6_cnt2", CsrAddrT'(Base + NumCh), 32'd2);
    expect_irq(cw + 3, "t6_rst", 4'b0000);
    expect_irq(cw + 4, "t6_noirq", 4'b0000);
    expect_irq(cw + 8, "t6_noirq2", 4'b0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd("t6_ctrl", Base, 32'd0);
    rd("t6_cnt", CsrAddrT'(Base + NumCh), 32'd0);
    tick_to(cw + 9);

`ifdef MTIMER_CASCADE_EN
    // ch1 counts ch0 expiries
    csr_wr(CsrAddrT'(Base + 1), CSR_WRITE, ctrl_word(1, 0, 0, 1, 2));
    csr_wr(Base, CSR_WRITE, ctrl_word(1, 0, 0, 0, 1));
    cw = cyc;
    expect_irq(cw + 5, "t7_pre", 4'b0001);
    expect_irq(cw + 6, "t7_fire", 4'b0011);
    tick_to(cw + 6);
    interrupt_clear = 4'b0010;
    @(posedge clk); #1;
    interrupt_clear = '0;
    expect_irq(cw + 7, "t7_clr", 4'b0001);
    expect_irq(cw + 11, "t7_pre2", 4'b0001);
    expect_irq(cw + 12, "t7_fire2", 4'b0011);
    tick_to(cw + 13);
    do_reset;
`endif

    @(posedge clk); #1;
    chk("sb_drain", exp_cyc_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
